// File: rtl/rram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rram_ctrl_pkg
// Purpose  : Shared types and default sizes for the RRAM command sequencer
//            and the rram_core it drives.
// Revision : 1.0 - initial release
// ============================================================================
package rram_ctrl_pkg;

    // Default core geometry, shared with rram_core
    localparam int NUM_ADCS = 32;
    localparam int ADC_BITS = 4;
    localparam int NUM_SEL  = 16;

    // Host command opcodes; the remaining encodings are illegal
    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_COMPUTE = 2'b01
    } op_e;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD_WL = 4'd1,
        ST_GAP1    = 4'd2,
        ST_LOAD_BL = 4'd3,
        ST_GAP2    = 4'd4,
        ST_PROG    = 4'd5,
        ST_SETTLE  = 4'd6,
        ST_SAMPLE  = 4'd7,
        ST_EMIT    = 4'd8
    } state_e;

    // True for the opcodes the sequencer knows how to execute
    function automatic logic op_legal(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_COMPUTE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rram_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : rram_delay_timer
// Purpose  : Loadable down-counter; done is high while the count is zero.
//            Loading N gives N more cycles before done rises.
// Revision : 1.0 - initial release
// ============================================================================
module rram_delay_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rram_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rram_cmd_sequencer
// Purpose  : Command-level controller for rram_core. Runs the WRITE
//            (wordline load, bitline load, program pulse) and COMPUTE
//            (wordline load, ADCSEL sweep, result streaming) sequences.
//            Every output is registered: the next-state logic computes the
//            value each output takes in the following cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rram_cmd_sequencer
    import rram_ctrl_pkg::*;
#(
    parameter int NUM_ADCS   = rram_ctrl_pkg::NUM_ADCS,
    parameter int ADC_BITS   = rram_ctrl_pkg::ADC_BITS,
    parameter int NUM_SEL    = rram_ctrl_pkg::NUM_SEL,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    // Host command port
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [DATA_W-1:0]             cmd_wl_data,
    input  logic [DATA_W-1:0]             cmd_bl_data,
    // Core drive and capture
    output logic                          WR_WL,
    output logic                          WR_BL,
    output logic                          WE,
    output logic                          RE,
    output logic [ADDR_W-1:0]             ADDR,
    output logic [DATA_W-1:0]             DATAIN,
    output logic [$clog2(NUM_SEL)-1:0]    ADCSEL,
    input  logic [NUM_ADCS*ADC_BITS-1:0]  ADCout,
    // Result port
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [NUM_ADCS*ADC_BITS-1:0]  res_data,
    output logic [$clog2(NUM_SEL)-1:0]    res_sel,
    output logic                          res_last,
    // Status
    output logic                          busy,
    output logic                          err_illegal
);

    localparam int SEL_W   = $clog2(NUM_SEL);
    localparam int RES_W   = NUM_ADCS * ADC_BITS;
    localparam int TMR_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    // Timer is loaded with N-1 so that the state lasts exactly N cycles
    localparam logic [TMR_W-1:0] PULSE_LOAD  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_SEL - 1);

    state_e               r_state;
    op_e                  r_op;
    logic [DATA_W-1:0]    r_bl;

    state_e               w_state_nxt;
    op_e                  w_op_nxt;
    logic [DATA_W-1:0]    w_bl_nxt;
    logic                 w_cmd_ready_nxt;
    logic                 w_wr_wl_nxt;
    logic                 w_wr_bl_nxt;
    logic                 w_we_nxt;
    logic                 w_re_nxt;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic [DATA_W-1:0]    w_datain_nxt;
    logic [SEL_W-1:0]     w_adcsel_nxt;
    logic                 w_res_valid_nxt;
    logic [RES_W-1:0]     w_res_data_nxt;
    logic [SEL_W-1:0]     w_res_sel_nxt;
    logic                 w_res_last_nxt;
    logic                 w_busy_nxt;
    logic                 w_err_nxt;
    logic                 w_tmr_load;
    logic [TMR_W-1:0]     w_tmr_val;
    logic                 w_tmr_done;

    // Shared timer for the program pulse and the ADC settle wait
    rram_delay_timer #(
        .CNT_W    (TMR_W)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    // Next state and next registered output values
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_bl_nxt        = r_bl;
        w_cmd_ready_nxt = cmd_ready;
        w_wr_wl_nxt     = 1'b0;
        w_wr_bl_nxt     = 1'b0;
        w_we_nxt        = 1'b0;
        w_re_nxt        = RE;
        w_addr_nxt      = ADDR;
        w_datain_nxt    = DATAIN;
        w_adcsel_nxt    = ADCSEL;
        w_res_valid_nxt = res_valid;
        w_res_data_nxt  = res_data;
        w_res_sel_nxt   = res_sel;
        w_res_last_nxt  = res_last;
        w_busy_nxt      = busy;
        w_err_nxt       = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (op_legal(cmd_op)) begin
                        // Wordline load is driven straight from the command
                        w_op_nxt        = op_e'(cmd_op);
                        w_bl_nxt        = cmd_bl_data;
                        w_addr_nxt      = cmd_addr;
                        w_datain_nxt    = cmd_wl_data;
                        w_wr_wl_nxt     = 1'b1;
                        w_cmd_ready_nxt = 1'b0;
                        w_busy_nxt      = 1'b1;
                        w_state_nxt     = ST_LOAD_WL;
                    end else begin
                        // Illegal op is consumed with no core activity
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD_WL: begin
                w_state_nxt = ST_GAP1;
            end
            ST_GAP1: begin
                if (r_op == OP_WRITE) begin
                    w_wr_bl_nxt  = 1'b1;
                    w_datain_nxt = r_bl;
                    w_state_nxt  = ST_LOAD_BL;
                end else begin
                    w_re_nxt     = 1'b1;
                    w_adcsel_nxt = '0;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = SETTLE_LOAD;
                    w_state_nxt  = ST_SETTLE;
                end
            end
            ST_LOAD_BL: begin
                w_state_nxt = ST_GAP2;
            end
            ST_GAP2: begin
                w_we_nxt    = 1'b1;
                w_tmr_load  = 1'b1;
                w_tmr_val   = PULSE_LOAD;
                w_state_nxt = ST_PROG;
            end
            ST_PROG: begin
                if (w_tmr_done) begin
                    w_cmd_ready_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_we_nxt = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_res_data_nxt  = ADCout;
                w_res_sel_nxt   = ADCSEL;
                w_res_last_nxt  = (ADCSEL == LAST_SEL);
                w_res_valid_nxt = 1'b1;
                w_state_nxt     = ST_EMIT;
            end
            ST_EMIT: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    if (res_last) begin
                        w_re_nxt        = 1'b0;
                        w_adcsel_nxt    = '0;
                        w_cmd_ready_nxt = 1'b1;
                        w_busy_nxt      = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_adcsel_nxt = ADCSEL + SEL_W'(1);
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = SETTLE_LOAD;
                        w_state_nxt  = ST_SETTLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched command fields and all registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_WRITE;
            r_bl        <= '0;
            cmd_ready   <= 1'b1;
            WR_WL       <= 1'b0;
            WR_BL       <= 1'b0;
            WE          <= 1'b0;
            RE          <= 1'b0;
            ADDR        <= '0;
            DATAIN      <= '0;
            ADCSEL      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_sel     <= '0;
            res_last    <= 1'b0;
            busy        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_bl        <= w_bl_nxt;
            cmd_ready   <= w_cmd_ready_nxt;
            WR_WL       <= w_wr_wl_nxt;
            WR_BL       <= w_wr_bl_nxt;
            WE          <= w_we_nxt;
            RE          <= w_re_nxt;
            ADDR        <= w_addr_nxt;
            DATAIN      <= w_datain_nxt;
            ADCSEL      <= w_adcsel_nxt;
            res_valid   <= w_res_valid_nxt;
            res_data    <= w_res_data_nxt;
            res_sel     <= w_res_sel_nxt;
            res_last    <= w_res_last_nxt;
            busy        <= w_busy_nxt;
            err_illegal <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rram_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rram_cmd_sequencer
// Purpose  : Directed self-checking bench for rram_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rram_cmd_sequencer;

    localparam int NUM_ADCS   = 32;
    localparam int ADC_BITS   = 4;
    localparam int NUM_SEL    = 16;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int PULSE_CYC  = 2;
    localparam int SETTLE_CYC = 4;
    localparam int SEL_W      = 4;
    localparam int RES_W      = NUM_ADCS * ADC_BITS;
    localparam int ALL_W      = 5 + ADDR_W + DATA_W + SEL_W + 1 + RES_W + SEL_W + 3;

    logic                 CLK = 1'b0;
    logic                 RESET_N = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = 2'b00;
    logic [ADDR_W-1:0]    cmd_addr = '0;
    logic [DATA_W-1:0]    cmd_wl_data = '0;
    logic [DATA_W-1:0]    cmd_bl_data = '0;
    logic                 WR_WL, WR_BL, WE, RE;
    logic [ADDR_W-1:0]    ADDR;
    logic [DATA_W-1:0]    DATAIN;
    logic [SEL_W-1:0]     ADCSEL;
    logic [RES_W-1:0]     ADCout;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [RES_W-1:0]     res_data;
    logic [SEL_W-1:0]     res_sel;
    logic                 res_last;
    logic                 busy;
    logic                 err_illegal;

    int tests = 0;
    int fails = 0;

    logic [5:0]       strb;
    logic [ALL_W-1:0] all_outs;
    logic [ALL_W-1:0] rst_outs;

    assign strb     = {WR_WL, WR_BL, WE, RE, cmd_ready, busy};
    assign all_outs = {cmd_ready, WR_WL, WR_BL, WE, RE, ADDR, DATAIN, ADCSEL,
                       res_valid, res_data, res_sel, res_last, busy, err_illegal};
    assign rst_outs = {1'b1, {(ALL_W-1){1'b0}}};

    // Core ADC model: every ADC reports the current ADCSEL value
    assign ADCout = {NUM_ADCS{ADCSEL}};

    always #5 CLK = ~CLK;

    rram_cmd_sequencer #(
        .NUM_ADCS   (NUM_ADCS),
        .ADC_BITS   (ADC_BITS),
        .NUM_SEL    (NUM_SEL),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PULSE_CYC  (PULSE_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wl_data (cmd_wl_data),
        .cmd_bl_data (cmd_bl_data),
        .WR_WL       (WR_WL),
        .WR_BL       (WR_BL),
        .WE          (WE),
        .RE          (RE),
        .ADDR        (ADDR),
        .DATAIN      (DATAIN),
        .ADCSEL      (ADCSEL),
        .ADCout      (ADCout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_sel     (res_sel),
        .res_last    (res_last),
        .busy        (busy),
        .err_illegal (err_illegal)
    );

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        tests++;
        if (all_outs !== rst_outs) begin
            fails++;
            $display("FAIL reset_values: got %h want %h", all_outs, rst_outs);
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        tests++;
        if (all_outs !== rst_outs) begin
            fails++;
            $display("FAIL idle_after_reset: got %h want %h", all_outs, rst_outs);
        end
    endtask

    // Cycle k is the clock period following handshake edge k
    task automatic test_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wl,
                              input logic [DATA_W-1:0] bl);
        logic [5:0] exp;
        @(negedge CLK);
        cmd_op = 2'b00; cmd_addr = a; cmd_wl_data = wl; cmd_bl_data = bl; cmd_valid = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            exp = {k == 1, k == 3, (k == 5) || (k == 6), 1'b0, k >= 7, k <= 6};
            tests++;
            if (strb !== exp) begin
                fails++;
                $display("FAIL write_strobes cyc%0d: got %b want %b", k, strb, exp);
            end
            if (k == 1) begin
                tests++;
                if ({ADDR, DATAIN} !== {a, wl}) begin
                    fails++;
                    $display("FAIL write_wl_data: got %h/%h want %h/%h", ADDR, DATAIN, a, wl);
                end
            end
            if (k == 3) begin
                tests++;
                if ({ADDR, DATAIN} !== {a, bl}) begin
                    fails++;
                    $display("FAIL write_bl_data: got %h/%h want %h/%h", ADDR, DATAIN, a, bl);
                end
            end
        end
    endtask

    task automatic test_compute(input bit stall);
        int cyc;
        int exp_cyc;
        int guard;
        logic [SEL_W-1:0] s;
        logic [RES_W-1:0] held;
        logic [5:0] exp_head [1:3];
        exp_head[1] = 6'b100001;
        exp_head[2] = 6'b000001;
        exp_head[3] = 6'b000101;
        @(negedge CLK);
        cmd_op = 2'b01; cmd_addr = 10'h155; cmd_wl_data = 32'hA5A5_0F0F; cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            tests++;
            if (strb !== exp_head[k]) begin
                fails++;
                $display("FAIL compute_head cyc%0d: got %b want %b", k, strb, exp_head[k]);
            end
        end
        cyc = 3;
        tests++;
        if (ADCSEL !== 4'd0) begin
            fails++;
            $display("FAIL compute_sel_start: got %0d want 0", ADCSEL);
        end
        exp_cyc = 4 + SETTLE_CYC;
        for (int i = 0; i < NUM_SEL; i++) begin
            s = SEL_W'(i);
            guard = 0;
            while (res_valid !== 1'b1 && guard < 40) begin
                @(negedge CLK);
                cyc++; guard++;
                tests++;
                if (RE !== 1'b1) begin
                    fails++;
                    $display("FAIL re_hold cyc%0d: got %b want 1", cyc, RE);
                end
            end
            if (res_valid !== 1'b1) begin
                tests++; fails++;
                $display("FAIL res_timeout result%0d: got res_valid=%b want 1", i, res_valid);
                return;
            end
            tests++;
            if (cyc !== exp_cyc) begin
                fails++;
                $display("FAIL res_timing result%0d: got cyc%0d want cyc%0d", i, cyc, exp_cyc);
            end
            tests++;
            if ({res_sel, res_last, res_data} !== {s, i == NUM_SEL - 1, {NUM_ADCS{s}}}) begin
                fails++;
                $display("FAIL res_content result%0d: got sel=%0d last=%b data=%h want sel=%0d last=%b",
                         i, res_sel, res_last, res_data, s, i == NUM_SEL - 1);
            end
            if (stall && i == 3) begin
                res_ready = 1'b0;
                held = res_data;
                repeat (10) begin
                    @(negedge CLK);
                    cyc++;
                    tests++;
                    if ({res_valid, RE, res_data, ADCSEL} !== {1'b1, 1'b1, held, 4'd3}) begin
                        fails++;
                        $display("FAIL stall_hold cyc%0d: got v=%b re=%b sel=%0d data=%h want v=1 re=1 sel=3 data=%h",
                                 cyc, res_valid, RE, ADCSEL, res_data, held);
                    end
                end
                res_ready = 1'b1;
            end
            exp_cyc = cyc + SETTLE_CYC + 2;
            @(negedge CLK);
            cyc++;
            tests++;
            if (res_valid !== 1'b0) begin
                fails++;
                $display("FAIL res_drop result%0d: got %b want 0", i, res_valid);
            end
        end
        tests++;
        if ({RE, ADCSEL, cmd_ready, busy} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL compute_end: got re=%b sel=%0d rdy=%b busy=%b want 0/0/1/0",
                     RE, ADCSEL, cmd_ready, busy);
        end
    endtask

    task automatic test_illegal();
        @(negedge CLK);
        cmd_op = 2'b10; cmd_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        tests++;
        if ({err_illegal, strb} !== {1'b1, 6'b000010}) begin
            fails++;
            $display("FAIL illegal_pulse: got err=%b strb=%b want err=1 strb=000010", err_illegal, strb);
        end
        @(negedge CLK);
        tests++;
        if ({err_illegal, strb} !== {1'b0, 6'b000010}) begin
            fails++;
            $display("FAIL illegal_after: got err=%b strb=%b want err=0 strb=000010", err_illegal, strb);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        @(negedge CLK);
        cmd_op = 2'b01; cmd_addr = 10'h0AA; cmd_wl_data = 32'h1234_5678; cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        guard = 0;
        while (!(res_valid === 1'b1 && res_sel === 4'd7) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        tests++;
        if (!(res_valid === 1'b1 && res_sel === 4'd7)) begin
            fails++;
            $display("FAIL reset_mid_reach: got v=%b sel=%0d want v=1 sel=7", res_valid, res_sel);
        end
        RESET_N = 1'b0;
        #1;
        tests++;
        if (all_outs !== rst_outs) begin
            fails++;
            $display("FAIL reset_async: got %h want %h", all_outs, rst_outs);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        tests++;
        if (all_outs !== rst_outs) begin
            fails++;
            $display("FAIL reset_release_idle: got %h want %h", all_outs, rst_outs);
        end
        test_write(10'h3FF, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    endtask

    initial begin
        test_reset();
        test_write(10'h000, 32'h0000_0001, 32'h0000_FFFF);
        test_compute(1'b0);
        test_compute(1'b1);
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
